// File: rtl/pdp8l_memcyc_init_pkg.sv
// Shared types for the PDP-8/L memory-cycle initiator: FSM states, op codes, ident.
// Pure declarations, no timing or flow-control behaviour of its own.
package pdp8l_memcyc_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      START  = 4'd1,
      WAITRL = 4'd2,
      WAITRH = 4'd3,
      WAITWL = 4'd4,
      WAITWH = 4'd5
   } state_t;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_RD  = 2'd1,
      OP_WR  = 2'd2,
      OP_INC = 2'd3
   } op_t;

   localparam logic [15:0] IDENT   = 16'h4D49;
   localparam logic [31:0] BAD_REG = 32'hDEADBEEF;

   // Layout of ARM register 1; also the layout of the command word written to it.
   typedef struct packed {
      logic        busy;
      logic        timeout;
      logic        carry;
      logic [11:0] data;
      op_t         op;
      logic [14:0] addr;
   } stat_t;

   typedef struct packed {
      logic [11:0] data;
      op_t         op;
      logic [14:0] addr;
   } cmd_t;

   // 12-bit increment with carry-out in bit 12.
   function automatic logic [12:0] inc12(input logic [11:0] v);
      return {1'b0, v} + 13'd1;
   endfunction

endpackage

// File: rtl/pdp8l_memcyc_init_if.sv
// ARM register port plus PDP-8/L break-cycle bus seen by the memory-cycle initiator.
// master = initiator side, slave = ARM/responder side.
interface pdp8l_memcyc_init_if;

   logic        armwrite;
   logic [1:0]  armraddr;
   logic [1:0]  armwaddr;
   logic [31:0] armwdata;
   logic [31:0] armrdata;

   logic        memstart;
   logic [11:0] memaddr;
   logic [11:0] memwdat;
   logic [2:0]  brkfld;
   logic        _bf_enab;
   logic [11:0] memrdat;
   logic        _mrdone;
   logic        _mwdone;

   modport master (
      input  armwrite, armraddr, armwaddr, armwdata, memrdat, _mrdone, _mwdone,
      output armrdata, memstart, memaddr, memwdat, brkfld, _bf_enab
   );

   modport slave (
      output armwrite, armraddr, armwaddr, armwdata, memrdat, _mrdone, _mwdone,
      input  armrdata, memstart, memaddr, memwdat, brkfld, _bf_enab
   );

endinterface

// File: rtl/pdp8l_memcyc_init.sv
// ARM-driven initiator issuing one PDP-8/L break memory cycle per command; memstart one cycle after the write.
// No backpressure: commands written while busy are dropped; every wait state aborts after TIMEOUT cycles.
module pdp8l_memcyc_init
   import pdp8l_memcyc_pkg::*;
#(
   parameter int unsigned TIMEOUT = 500,
   parameter logic [11:0] VERSION = 12'h001
) (
   input  logic                       CLOCK,
   input  logic                       RESET,
   pdp8l_memcyc_init_if.master        mif
);

   localparam logic [9:0] TO_LIMIT = TIMEOUT[9:0];

   state_t      state_q, state_d;
   stat_t       stat_q, stat_d;
   logic [9:0]  tocount_q, tocount_d;
   logic        memstart_q, memstart_d;
   logic [11:0] memaddr_q, memaddr_d;
   logic [11:0] memwdat_q, memwdat_d;
   logic [2:0]  brkfld_q, brkfld_d;
   logic        bf_enab_n_q, bf_enab_n_d;

   cmd_t        cmd;
   logic        wr_cmd;
   logic        waiting;
   logic [12:0] inc_val;
   logic [31:0] rdata;
   logic        unused_wdata;

   assign cmd          = cmd_t'(mif.armwdata[28:0]);
   assign unused_wdata = ^mif.armwdata[31:29];
   assign wr_cmd       = mif.armwrite && (mif.armwaddr == 2'd1) && !stat_q.busy;
   assign waiting      = (state_q == WAITRL) || (state_q == WAITRH) ||
                         (state_q == WAITWL) || (state_q == WAITWH);
   assign inc_val      = inc12(mif.memrdat);

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q     <= IDLE;
         stat_q      <= '0;
         tocount_q   <= '0;
         memstart_q  <= 1'b0;
         memaddr_q   <= '0;
         memwdat_q   <= '0;
         brkfld_q    <= '0;
         bf_enab_n_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         stat_q      <= stat_d;
         tocount_q   <= tocount_d;
         memstart_q  <= memstart_d;
         memaddr_q   <= memaddr_d;
         memwdat_q   <= memwdat_d;
         brkfld_q    <= brkfld_d;
         bf_enab_n_q <= bf_enab_n_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      stat_d      = stat_q;
      tocount_d   = tocount_q;
      memstart_d  = 1'b0;
      memaddr_d   = memaddr_q;
      memwdat_d   = memwdat_q;
      brkfld_d    = brkfld_q;
      bf_enab_n_d = bf_enab_n_q;

      case (state_q)
         IDLE: begin
            if (wr_cmd) begin
               stat_d.timeout = 1'b0;
               stat_d.carry   = 1'b0;
               if (cmd.op != OP_NOP) begin
                  stat_d.busy = 1'b1;
                  stat_d.op   = cmd.op;
                  stat_d.addr = cmd.addr;
                  if (cmd.op == OP_WR) stat_d.data = cmd.data;
                  // Bus outputs are loaded here so they are already valid while START is held.
                  memstart_d  = 1'b1;
                  memaddr_d   = cmd.addr[11:0];
                  brkfld_d    = cmd.addr[14:12];
                  bf_enab_n_d = 1'b0;
                  state_d     = START;
               end
            end
         end
         START: state_d = WAITRL;
         WAITRL: begin
            if (!mif._mrdone) begin
               case (stat_q.op)
                  OP_WR: memwdat_d = stat_q.data;
                  OP_INC: begin
                     stat_d.data  = inc_val[11:0];
                     stat_d.carry = inc_val[12];
                     memwdat_d    = inc_val[11:0];
                  end
                  default: begin
                     stat_d.data = mif.memrdat;
                     memwdat_d   = mif.memrdat;
                  end
               endcase
               state_d = WAITRH;
            end
         end
         WAITRH: if (mif._mrdone) state_d = WAITWL;
         WAITWL: if (!mif._mwdone) state_d = WAITWH;
         WAITWH: begin
            if (mif._mwdone) begin
               stat_d.busy = 1'b0;
               bf_enab_n_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) begin
         tocount_d = '0;
      end else if (waiting) begin
         if (tocount_q == TO_LIMIT) begin
            stat_d.timeout = 1'b1;
            stat_d.busy    = 1'b0;
            bf_enab_n_d    = 1'b1;
            state_d        = IDLE;
            tocount_d      = '0;
         end else begin
            tocount_d = tocount_q + 10'd1;
         end
      end
   end

   always_comb begin
      rdata = BAD_REG;
      case (mif.armraddr)
         2'd0:    rdata = {IDENT, 4'h1, VERSION};
         2'd1:    rdata = stat_q;
         2'd2:    rdata = {state_q, 16'h0000, tocount_q, mif._mrdone, mif._mwdone};
         default: rdata = BAD_REG;
      endcase
   end

   assign mif.armrdata = rdata;
   assign mif.memstart = memstart_q;
   assign mif.memaddr  = memaddr_q;
   assign mif.memwdat  = memwdat_q;
   assign mif.brkfld   = brkfld_q;
   assign mif._bf_enab = bf_enab_n_q;

endmodule

// File: tb/tb_pdp8l_memcyc_init.sv
// Directed bench for pdp8l_memcyc_init with a behavioural extended-memory responder and write scoreboard.
module tb_pdp8l_memcyc_init;

   localparam int TO = 500;

   typedef struct packed {
      logic [14:0] a;
      logic [11:0] d;
   } exp_t;

   logic CLOCK;
   logic RESET;
   pdp8l_memcyc_init_if bus();

   pdp8l_memcyc_init #(.TIMEOUT(TO), .VERSION(12'h001)) dut (
      .CLOCK(CLOCK),
      .RESET(RESET),
      .mif  (bus.master)
   );

   int          checks = 0;
   int          errors = 0;
   int          starts = 0;
   int          resp_mode = 0;   // 0 normal, 1 never answers, 2 read half only
   exp_t        exp_q[$];
   logic [11:0] mem [0:32767];
   logic [14:0] r_a;
   logic [11:0] r_wd;
   exp_t        r_e;

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] mk1(input logic b, input logic t, input logic c,
                                       input logic [11:0] d, input logic [1:0] op, input logic [14:0] a);
      return {b, t, c, d, op, a};
   endfunction

   task automatic arm_wr(input logic [1:0] wa, input logic [31:0] wd);
      @(negedge CLOCK);
      bus.armwaddr = wa;
      bus.armwdata = wd;
      bus.armwrite = 1'b1;
      @(negedge CLOCK);
      bus.armwrite = 1'b0;
   endtask

   task automatic cmd(input logic [1:0] op, input logic [14:0] a, input logic [11:0] d);
      arm_wr(2'd1, {3'b000, d, op, a});
   endtask

   task automatic rd(input logic [1:0] ra, output logic [31:0] v);
      bus.armraddr = ra;
      #1;
      v = bus.armrdata;
   endtask

   task automatic wait_idle(input string tag, output int cyc);
      cyc = 0;
      bus.armraddr = 2'd1;
      #1;
      while (bus.armrdata[31] && cyc < 3000) begin
         @(negedge CLOCK);
         #1;
         cyc++;
      end
      chk({tag, "_idle"}, {31'b0, bus.armrdata[31]}, 32'd0);
   endtask

   always @(negedge CLOCK) if (bus.memstart === 1'b1) starts++;

   // Extended-memory responder: read strobe, then write strobe after the memwdat settle window.
   initial begin
      forever begin
         @(negedge CLOCK);
         if (bus.memstart === 1'b1 && resp_mode != 1) begin
            r_a = {bus.brkfld, bus.memaddr};
            repeat (3) @(negedge CLOCK);
            bus.memrdat = mem[r_a];
            bus._mrdone = 1'b0;
            repeat (4) @(negedge CLOCK);
            bus._mrdone = 1'b1;
            repeat (35) @(negedge CLOCK);
            r_wd = bus.memwdat;
            if (resp_mode == 0) begin
               bus._mwdone = 1'b0;
               repeat (3) @(negedge CLOCK);
               chk("wdat_stable", {20'b0, bus.memwdat}, {20'b0, r_wd});
               bus._mwdone = 1'b1;
               mem[r_a] = r_wd;
               chk("sb_pending", {31'b0, exp_q.size() != 0}, 32'd1);
               if (exp_q.size() != 0) begin
                  r_e = exp_q.pop_front();
                  chk("sb_addr", {17'b0, r_a}, {17'b0, r_e.a});
                  chk("sb_wdat", {20'b0, r_wd}, {20'b0, r_e.d});
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] v;
      int          cyc;
      int          s0;

      for (int i = 0; i < 32768; i++) mem[i] = 12'o0;
      RESET        = 1'b1;
      bus.armwrite = 1'b0;
      bus.armraddr = 2'd0;
      bus.armwaddr = 2'd0;
      bus.armwdata = 32'd0;
      bus.memrdat  = 12'd0;
      bus._mrdone  = 1'b1;
      bus._mwdone  = 1'b1;
      repeat (3) @(negedge CLOCK);
      RESET = 1'b0;
      #1;

      // Reset state and register map
      chk("rst_memstart", {31'b0, bus.memstart}, 32'd0);
      chk("rst_memaddr",  {20'b0, bus.memaddr}, 32'd0);
      chk("rst_memwdat",  {20'b0, bus.memwdat}, 32'd0);
      chk("rst_brkfld",   {29'b0, bus.brkfld}, 32'd0);
      chk("rst_bf_enab",  {31'b0, bus._bf_enab}, 32'd1);
      rd(2'd0, v); chk("reg0_ident", v, 32'h4D49_1001);
      rd(2'd1, v); chk("rst_reg1", v, 32'd0);
      rd(2'd2, v); chk("rst_reg2", v, 32'h0000_0003);
      rd(2'd3, v); chk("reg3_bad", v, 32'hDEADBEEF);

      // Write cycle
      s0 = starts;
      exp_q.push_back('{a: 15'o31234, d: 12'o5670});
      cmd(2'd2, 15'o31234, 12'o5670);
      #1;
      chk("wr_memstart", {31'b0, bus.memstart}, 32'd1);
      chk("wr_memaddr",  {20'b0, bus.memaddr}, {20'b0, 12'o1234});
      chk("wr_brkfld",   {29'b0, bus.brkfld}, 32'd3);
      chk("wr_bf_enab",  {31'b0, bus._bf_enab}, 32'd0);
      wait_idle("wr", cyc);
      rd(2'd1, v); chk("wr_reg1", v, mk1(0, 0, 0, 12'o5670, 2'd2, 15'o31234));
      chk("wr_mem", {20'b0, mem[15'o31234]}, {20'b0, 12'o5670});
      chk("wr_starts", starts - s0, 32'd1);
      chk("wr_bf_idle", {31'b0, bus._bf_enab}, 32'd1);
      chk("wr_hold_addr", {20'b0, bus.memaddr}, {20'b0, 12'o1234});

      // Read/restore
      exp_q.push_back('{a: 15'o31234, d: 12'o5670});
      cmd(2'd1, 15'o31234, 12'o0);
      wait_idle("rd", cyc);
      rd(2'd1, v); chk("rd_reg1", v, mk1(0, 0, 0, 12'o5670, 2'd1, 15'o31234));

      // Increment wrapping 7777 -> 0, then a plain increment
      mem[15'o00017] = 12'o7777;
      exp_q.push_back('{a: 15'o00017, d: 12'o0000});
      cmd(2'd3, 15'o00017, 12'o0);
      wait_idle("incw", cyc);
      rd(2'd1, v); chk("incw_reg1", v, mk1(0, 0, 1, 12'o0000, 2'd3, 15'o00017));
      chk("incw_mem", {20'b0, mem[15'o00017]}, 32'd0);
      exp_q.push_back('{a: 15'o00017, d: 12'o0001});
      cmd(2'd3, 15'o00017, 12'o0);
      wait_idle("inc", cyc);
      rd(2'd1, v); chk("inc_reg1", v, mk1(0, 0, 0, 12'o0001, 2'd3, 15'o00017));

      // Timeout with a silent responder
      resp_mode = 1;
      s0 = starts;
      cmd(2'd1, 15'o00100, 12'o0);
      repeat (10) @(negedge CLOCK);
      rd(2'd2, v); chk("to_reg2_count", v, {4'd2, 16'h0, 10'd9, 1'b1, 1'b1});
      wait_idle("to", cyc);
      chk("to_cycles", {31'b0, (cyc + 10 >= TO) && (cyc + 10 <= TO + 5)}, 32'd1);
      rd(2'd1, v); chk("to_reg1", v, mk1(0, 1, 0, 12'o0001, 2'd1, 15'o00100));
      chk("to_bf_enab", {31'b0, bus._bf_enab}, 32'd1);
      repeat (20) @(negedge CLOCK);
      chk("to_starts", starts - s0, 32'd1);
      cmd(2'd0, 15'o0, 12'o0);
      rd(2'd1, v); chk("nop_clear", v, mk1(0, 0, 0, 12'o0001, 2'd1, 15'o00100));
      resp_mode = 0;

      // Busy lockout
      mem[15'o04444] = 12'o0;
      s0 = starts;
      exp_q.push_back('{a: 15'o02222, d: 12'o1111});
      cmd(2'd2, 15'o02222, 12'o1111);
      repeat (5) @(negedge CLOCK);
      cmd(2'd2, 15'o04444, 12'o7777);
      wait_idle("lock", cyc);
      rd(2'd1, v); chk("lock_reg1", v, mk1(0, 0, 0, 12'o1111, 2'd2, 15'o02222));
      chk("lock_starts", starts - s0, 32'd1);
      chk("lock_mem_other", {20'b0, mem[15'o04444]}, 32'd0);

      // Reset in WAITWL
      resp_mode = 2;
      cmd(2'd1, 15'o00017, 12'o0);
      cyc = 0;
      bus.armraddr = 2'd2;
      #1;
      while (bus.armrdata[31:28] != 4'd4 && cyc < 200) begin
         @(negedge CLOCK);
         #1;
         cyc++;
      end
      chk("rst_reach_waitwl", {28'b0, bus.armrdata[31:28]}, 32'd4);
      RESET = 1'b1;
      @(negedge CLOCK);
      RESET = 1'b0;
      #1;
      rd(2'd2, v); chk("mid_reg2", v, 32'h0000_0003);
      rd(2'd1, v); chk("mid_reg1", v, 32'd0);
      chk("mid_memaddr", {20'b0, bus.memaddr}, 32'd0);
      chk("mid_memwdat", {20'b0, bus.memwdat}, 32'd0);
      chk("mid_bf_enab", {31'b0, bus._bf_enab}, 32'd1);
      s0 = starts;
      repeat (60) @(negedge CLOCK);
      chk("mid_no_start", starts - s0, 32'd0);
      resp_mode = 0;
      exp_q.push_back('{a: 15'o00017, d: 12'o0001});
      cmd(2'd1, 15'o00017, 12'o0);
      wait_idle("post", cyc);
      rd(2'd1, v); chk("post_reg1", v, mk1(0, 0, 0, 12'o0001, 2'd1, 15'o00017));

      repeat (5) @(negedge CLOCK);
      chk("sb_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pdp8l_memcyc_init.md
Name: pdp8l_memcyc_init

Overview:
ARM-driven initiator for the PDP-8/L memory-cycle interface. It is the CPU-side end of the protocol that the extended-memory responder serves.
- Issues one break-style memory cycle per ARM command: memstart pulse, field on brkfld with _bf_enab low, address and write data.
- Waits for the responder's _mrdone and _mwdone strobes.
- Used for DMA-style access and to exercise extended memory from the CPU side without the real processor.

Parameters:
TIMEOUT, 500, max CLOCK cycles spent in any wait state before aborting (10 ns clock, so 5 us; must be ≤ 1023).
VERSION, 12'h001, version field of ident register.

Ports:
CLOCK  in  1  system clock, single clock domain.
RESET  in  1  synchronous, active-high reset.
armwrite  in  1  one-cycle ARM register write strobe.
armraddr  in  2  ARM read register select.
armwaddr  in  2  ARM write register select.
armwdata  in  32  ARM write data.
armrdata  out  32  ARM read data, combinational.
memstart  out  1  one-cycle pulse starting a memory cycle.
memaddr  out  12  address within field.
memwdat  out  12  data to be written back in the write half of the cycle.
brkfld  out  3  field for the break cycle.
_bf_enab  out  1  low while a cycle is in progress (break field select).
memrdat  in  12  read data from responder.
_mrdone  in  1  active-low read-done strobe.
_mwdone  in  1  active-low write-done strobe.

Behaviour:
- Clock and reset: one clock (CLOCK); reset is synchronous and active-high (RESET).
- Reset values:
  - memstart=0, memaddr=0, memwdat=0, brkfld=0, _bf_enab=1.
  - State=IDLE; busy=0, timeout=0, carry=0, data=0, op=0, addr=0.
  - Reset mid-cycle aborts immediately to IDLE with these values; no strobes are issued afterwards.
- ARM register map:
  - [0] = 32'h4D49_1000 | VERSION ('MI', 2^2 regs).
  - [1] = busy[31] timeout[30] carry[29] data[28:17] op[16:15] addr[14:0].
  - [2] = state[31:28], 0[27:12], tocount[11:2], _mrdone[1], _mwdone[0].
  - Other read values: 32'hDEADBEEF.
- Writes to [1]:
  - Ignored entirely while busy=1.
  - op=0: clears timeout and carry only.
  - op=1 read/restore, op=2 write, op=3 increment: latch addr, op, and data (data only for op=2); clear timeout and carry; busy<=1; enter START.
  - Writes to other addresses are ignored.
- State machine (tocount clears on every transition):
  - IDLE: outputs idle, _bf_enab=1.
  - START: drive memaddr=addr[11:0], brkfld=addr[14:12], _bf_enab=0, memstart=1 for exactly one cycle → WAITRL.
  - WAITRL: on _mrdone=0, capture memrdat into data and set memwdat the same cycle → WAITRH.
    - op=1: memwdat=memrdat.
    - op=2: memwdat=latched data; data register keeps the written value.
    - op=3: memwdat=(memrdat+1) mod 4096; carry=1 iff memrdat=12'o7777; data=incremented value.
  - WAITRH: wait _mrdone=1 → WAITWL.
  - WAITWL: wait _mwdone=0 → WAITWH.
  - WAITWH: wait _mwdone=1 → IDLE with busy<=0 and _bf_enab<=1. memaddr, brkfld and memwdat hold their values until the next START.
- Handshake rules:
  - memwdat stays stable from WAITRL exit until IDLE, because the responder samples it roughly 350 ns after _mrdone falls.
  - _mwdone is ignored in WAITRL/WAITRH; _mrdone is ignored in WAITWL/WAITWH.
  - A strobe already low on entry to a "wait low" state counts immediately.
- Timeout: in any WAIT state, if tocount reaches TIMEOUT, set timeout=1, busy=0, _bf_enab=1 and go to IDLE. data then holds whatever was last captured.
- Simultaneous armwrite and state completion in the same cycle: the completion wins and the write is ignored, because busy is still 1 in that cycle.

Decomposition:
- Shared package pdp8l_memcyc_pkg holds:
  - state enum (IDLE, START, WAITRL, WAITRH, WAITWL, WAITWH);
  - op codes (OP_NOP=0, OP_RD=1, OP_WR=2, OP_INC=3);
  - ident constant 16'h4D49.
- No sub-module. A single module is natural; the ARM register decode is small enough to live inline.

Test Plan:
- Write: ARM writes [1] op=2, addr=15'o31234, data=12'o5670 → one memstart pulse; memaddr=12'o1234, brkfld=3, _bf_enab=0; memwdat=12'o5670 after _mrdone falls; busy clears after _mwdone rises; responder memory holds 12'o5670.
- Read/restore: op=1 on the same address → [1] data=12'o5670; memwdat=12'o5670 written back; timeout=0, carry=0.
- Increment wrap: memory holds 12'o7777 at addr 15'o00017, op=3 → data=0, carry=1, written value 0.
- Timeout: responder never asserts _mrdone, op=1 → after TIMEOUT cycles in WAITRL, timeout=1, busy=0, _bf_enab=1; no further memstart.
- Busy lockout: a second [1] write with a different addr issued mid-cycle → ignored; the cycle completes with the original addr; exactly one memstart seen.
- Reset mid-cycle: RESET asserted in WAITWL → next cycle state=IDLE, _bf_enab=1, all outputs at reset values; a later op=1 completes normally.
